// File: rtl/fifo_sync_umbral.sv
// -----------------------------------------------------------------------------
// fifo_sync_umbral
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full / almost-empty thresholds and one-cycle overflow / underflow
// pulses. FWFT selects registered-read output (0) or first-word-fall-through
// output (1).
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   push          in   write request
//   pop           in   read request
//   FIFO_data_in  in   [data_width-1:0] write data
//   af_thr        in   [address_width:0] almost-full threshold (words)
//   ae_thr        in   [address_width:0] almost-empty threshold (words)
//   FIFO_data_out out  [data_width-1:0] read data
//   count         out  [address_width:0] occupancy 0..DEPTH
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= af_thr
//   almost_empty  out  count <= ae_thr
//   overflow      out  one-cycle pulse, push rejected
//   underflow     out  one-cycle pulse, pop rejected
// -----------------------------------------------------------------------------
module fifo_sync_umbral #(
    parameter int data_width    = 10,
    parameter int address_width = 3,
    parameter int FWFT          = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [data_width-1:0]    FIFO_data_in,
    input  logic [address_width:0]   af_thr,
    input  logic [address_width:0]   ae_thr,
    output logic [data_width-1:0]    FIFO_data_out,
    output logic [address_width:0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int                   DEPTH   = 1 << address_width;
    localparam logic [address_width:0] DEPTH_W = {1'b1, {address_width{1'b0}}};
    localparam logic [address_width:0] ZERO_W  = {(address_width+1){1'b0}};

    logic [data_width-1:0]    mem_r [0:DEPTH-1];
    logic [address_width-1:0] rd_ptr_r;
    logic [address_width-1:0] wr_ptr_r;
    logic [address_width:0]   count_r;
    logic [data_width-1:0]    dout_r;
    logic                     full_r;
    logic                     empty_r;
    logic                     af_r;
    logic                     ae_r;
    logic                     ovf_r;
    logic                     unf_r;
    // Set by reset until the first clock edge; almost_full must track
    // af_thr during that window because the flag has no registered value yet.
    logic                     fresh_r;

    logic                     pop_ok_s;
    logic                     push_ok_s;
    logic [address_width:0]   count_nxt_s;
    logic [address_width-1:0] rd_ptr_nxt_s;
    logic [address_width-1:0] wr_ptr_nxt_s;
    logic [data_width-1:0]    dout_nxt_s;

    // Acceptance, next-state occupancy, pointers and next output word.
    always_comb begin
        pop_ok_s     = pop & ~empty_r;
        push_ok_s    = push & (~full_r | pop_ok_s);
        count_nxt_s  = count_r + (address_width+1)'(push_ok_s)
                               - (address_width+1)'(pop_ok_s);
        rd_ptr_nxt_s = rd_ptr_r + address_width'(pop_ok_s);
        wr_ptr_nxt_s = wr_ptr_r + address_width'(push_ok_s);
        dout_nxt_s   = dout_r;
        if (FWFT != 0) begin
            if (count_nxt_s == ZERO_W) begin
                // Nothing left to present: keep the last word shown.
                dout_nxt_s = dout_r;
            end else if (push_ok_s && ((count_r - (address_width+1)'(pop_ok_s)) == ZERO_W)) begin
                // The new head is the word being written this cycle; memory
                // does not hold it yet, so bypass the input.
                dout_nxt_s = FIFO_data_in;
            end else begin
                dout_nxt_s = mem_r[rd_ptr_nxt_s];
            end
        end else begin
            if (pop_ok_s) begin
                dout_nxt_s = mem_r[rd_ptr_r];
            end else begin
                dout_nxt_s = dout_r;
            end
        end
    end

    // Storage array; not reset, and writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (push_ok_s && reset) begin
            mem_r[wr_ptr_r] <= FIFO_data_in;
        end
    end

    // Pointers, count, output word and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r <= {address_width{1'b0}};
            wr_ptr_r <= {address_width{1'b0}};
            count_r  <= ZERO_W;
            dout_r   <= {data_width{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            af_r     <= 1'b0;
            ae_r     <= 1'b1;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            fresh_r  <= 1'b1;
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= count_nxt_s;
            dout_r   <= dout_nxt_s;
            full_r   <= (count_nxt_s == DEPTH_W);
            empty_r  <= (count_nxt_s == ZERO_W);
            af_r     <= (count_nxt_s >= af_thr);
            ae_r     <= (count_nxt_s <= ae_thr);
            ovf_r    <= push & full_r & ~pop;
            unf_r    <= pop & empty_r;
            fresh_r  <= 1'b0;
        end
    end

    assign FIFO_data_out = dout_r;
    assign count         = count_r;
    assign full          = full_r;
    assign empty         = empty_r;
    assign almost_full   = fresh_r ? (af_thr == ZERO_W) : af_r;
    assign almost_empty  = ae_r;
    assign overflow      = ovf_r;
    assign underflow     = unf_r;

endmodule

// File: tb/tb_fifo_sync_umbral.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_umbral
// Directed bench for fifo_sync_umbral: one registered-read instance and one
// FWFT instance share the stimulus. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_fifo_sync_umbral;

    logic       clk;
    logic       reset;
    logic       push;
    logic       pop;
    logic [9:0] din;
    logic [3:0] af_thr;
    logic [3:0] ae_thr;

    logic [9:0] dout;
    logic [3:0] count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    logic [9:0] dout2;
    logic [3:0] count2;
    logic       full2, empty2, almost_full2, almost_empty2, overflow2, underflow2;

    int n_checks;
    int n_errors;

    fifo_sync_umbral #(.data_width(10), .address_width(3), .FWFT(0)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .FIFO_data_in(din), .af_thr(af_thr), .ae_thr(ae_thr),
        .FIFO_data_out(dout), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_sync_umbral #(.data_width(10), .address_width(3), .FWFT(1)) dut_fwft (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .FIFO_data_in(din), .af_thr(af_thr), .ae_thr(ae_thr),
        .FIFO_data_out(dout2), .count(count2), .full(full2), .empty(empty2),
        .almost_full(almost_full2), .almost_empty(almost_empty2),
        .overflow(overflow2), .underflow(underflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic cycle(input logic p_push, input logic p_pop, input logic [9:0] p_din);
        push = p_push;
        pop  = p_pop;
        din  = p_din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset  = 1'b1;
        push   = 1'b1;
        pop    = 1'b0;
        din    = 10'h3FF;
        af_thr = 4'd6;
        ae_thr = 4'd2;

        // ---- 1: reset held with push active ----
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_count", count, 32'd0);
        check_eq("rst_empty", empty, 32'd1);
        check_eq("rst_full", full, 32'd0);
        check_eq("rst_dout", dout, 32'd0);
        check_eq("rst_ae", almost_empty, 32'd1);
        check_eq("rst_af", almost_full, 32'd0);
        check_eq("rst_ovf", overflow, 32'd0);
        check_eq("rst_unf", underflow, 32'd0);
        af_thr = 4'd0;
        #1;
        check_eq("rst_af_thr0", almost_full, 32'd1);
        af_thr = 4'd6;
        #1;
        reset = 1'b1;
        push  = 1'b0;

        // ---- 2: fill ----
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 10'h090 + 10'(i));
            check_eq("fill_count", count, 32'(i + 1));
            check_eq("fill_af", almost_full, (i + 1 >= 6) ? 32'd1 : 32'd0);
            check_eq("fill_ae", almost_empty, (i + 1 <= 2) ? 32'd1 : 32'd0);
        end
        check_eq("fill_full", full, 32'd1);
        check_eq("fill_dout_unchanged", dout, 32'd0);
        cycle(1'b1, 1'b0, 10'h098);
        check_eq("ovf_pulse", overflow, 32'd1);
        check_eq("ovf_count", count, 32'd8);
        cycle(1'b0, 1'b0, 10'h000);
        check_eq("ovf_clear", overflow, 32'd0);

        // ---- 3: drain ----
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 10'h000);
            check_eq("drain_dout", dout, 32'h090 + 32'(i));
            check_eq("drain_count", count, 32'(7 - i));
            check_eq("drain_ae", almost_empty, (7 - i <= 2) ? 32'd1 : 32'd0);
        end
        check_eq("drain_empty", empty, 32'd1);
        cycle(1'b0, 1'b1, 10'h000);
        check_eq("unf_pulse", underflow, 32'd1);
        check_eq("unf_hold", dout, 32'h097);
        cycle(1'b0, 1'b0, 10'h000);
        check_eq("unf_clear", underflow, 32'd0);

        // ---- 4: wrap and simultaneous push/pop ----
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 10'h100 + 10'(i));
        for (int j = 0; j < 12; j++) begin
            cycle(1'b1, 1'b1, 10'h104 + 10'(j));
            check_eq("wrap_dout", dout, 32'h100 + 32'(j));
            check_eq("wrap_count", count, 32'd4);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 10'h110 + 10'(i));
        check_eq("full2_count", count, 32'd8);
        cycle(1'b1, 1'b1, 10'h114);
        check_eq("fullpp_count", count, 32'd8);
        check_eq("fullpp_ovf", overflow, 32'd0);
        check_eq("fullpp_dout", dout, 32'h10C);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 10'h000);
            check_eq("order_dout", dout, (i < 3) ? (32'h10D + 32'(i)) : (32'h110 + 32'(i - 3)));
        end
        check_eq("order_empty", empty, 32'd1);
        cycle(1'b1, 1'b1, 10'h120);
        check_eq("emptypp_count", count, 32'd1);
        check_eq("emptypp_unf", underflow, 32'd1);
        check_eq("emptypp_dout", dout, 32'h114);
        cycle(1'b0, 1'b1, 10'h000);
        check_eq("emptypp_pop", dout, 32'h120);

        // ---- 5: reset mid-operation ----
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 10'h0A0 + 10'(i));
        check_eq("mid_count5", count, 32'd5);
        push  = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("mid_count", count, 32'd0);
        check_eq("mid_empty", empty, 32'd1);
        check_eq("mid_ae", almost_empty, 32'd1);
        check_eq("mid_dout", dout, 32'd0);
        #1 reset = 1'b1;
        cycle(1'b1, 1'b0, 10'h0AA);
        check_eq("mid_push_count", count, 32'd1);
        cycle(1'b0, 1'b1, 10'h000);
        check_eq("mid_pop_dout", dout, 32'h0AA);

        // Threshold changes and out-of-range thresholds.
        ae_thr = 4'd0;
        cycle(1'b1, 1'b0, 10'h055);
        check_eq("thr_ae0", almost_empty, 32'd0);
        af_thr = 4'd1;
        cycle(1'b0, 1'b0, 10'h000);
        check_eq("thr_af1", almost_full, 32'd1);
        af_thr = 4'd15;
        ae_thr = 4'd15;
        cycle(1'b0, 1'b0, 10'h000);
        check_eq("thr_af15", almost_full, 32'd0);
        check_eq("thr_ae15", almost_empty, 32'd1);
        cycle(1'b0, 1'b1, 10'h000);
        af_thr = 4'd6;
        ae_thr = 4'd2;

        // ---- 6: FWFT instance ----
        reset = 1'b0;
        #1;
        check_eq("fwft_rst_dout", dout2, 32'd0);
        check_eq("fwft_rst_empty", empty2, 32'd1);
        #1 reset = 1'b1;
        cycle(1'b1, 1'b0, 10'h123);
        check_eq("fwft_empty_fall", empty2, 32'd0);
        check_eq("fwft_first", dout2, 32'h123);
        cycle(1'b1, 1'b0, 10'h124);
        check_eq("fwft_head_stable", dout2, 32'h123);
        cycle(1'b0, 1'b1, 10'h000);
        check_eq("fwft_next", dout2, 32'h124);
        check_eq("fwft_count1", count2, 32'd1);
        cycle(1'b0, 1'b1, 10'h000);
        check_eq("fwft_empty", empty2, 32'd1);
        check_eq("fwft_hold", dout2, 32'h124);
        cycle(1'b0, 1'b1, 10'h000);
        check_eq("fwft_unf", underflow2, 32'd1);
        check_eq("fwft_hold2", dout2, 32'h124);
        cycle(1'b1, 1'b0, 10'h130);
        check_eq("fwft_push", dout2, 32'h130);
        cycle(1'b1, 1'b1, 10'h131);
        check_eq("fwft_pp_dout", dout2, 32'h131);
        check_eq("fwft_pp_count", count2, 32'd1);
        cycle(1'b0, 1'b1, 10'h000);
        check_eq("fwft_last_hold", dout2, 32'h131);
        check_eq("fwft_last_empty", empty2, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
